wdata_burst_sequencer: RTL and testbench
========================================

WDATA_BURST_SEQUENCER -- requirements
Module: wdata_burst_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): DW, 128, write-data beat width. PEND_DEPTH, 4, pending-write queue depth, power of 2.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_issue  in  1  one-cycle pulse; the command scheduler issued a WRITE to DRAM this cycle.
- cwl  in  4  write latency in cycles, legal 2..15; sampled per command at wr_issue.
- bl8  in  1  burst length select: 0 = 4 beats, 1 = 8 beats; sampled per command at wr_issue.
- fifo_empty  in  1  write-data FIFO empty.
- fifo_data  in  DW  write-data FIFO head word, first-word-fall-through.
- fifo_ren  out  1  pop request to the write-data FIFO.
- dq_out  out  DW  registered write data to the PHY.
- dq_valid  out  1  dq_out holds a burst beat.
- pend_full  out  1  pending queue holds PEND_DEPTH entries.
- busy  out  1  pending queue non-empty or a burst in progress.
- err_clr  in  1  clears all sticky error flags.
- err_overflow  out  1  sticky; a wr_issue was dropped because the queue was full.
- err_underflow  out  1  sticky; a beat was needed while fifo_empty=1.
- err_collision  out  1  sticky; a burst start was delayed by a preceding burst.

Function
REQ-003 SHALL push {cwl, bl8, countdown} into the pending queue on each wr_issue sampled while pend_full=0.
REQ-004 SHALL, for wr_issue sampled at edge T and no collision, assert fifo_ren in cycles T+cwl-1 through T+cwl+BL-2, where BL = 4 or 8.
REQ-005 SHALL assert dq_valid in cycles T+cwl through T+cwl+BL-1, with dq_out equal to the fifo_data value present during the preceding fifo_ren cycle.
REQ-006 SHALL decrement the countdown of every pending entry each cycle, saturating at zero.
REQ-007 SHALL pop the head queue entry at the cycle its burst's first fifo_ren is asserted.
REQ-008 SHALL implement the FSM IDLE -> BURST when the head entry is due; BURST -> IDLE after the last beat if no entry is due; BURST -> BURST seamlessly (no idle cycle) if the next entry is due on the cycle after the last fifo_ren.
REQ-009 SHALL use a beat counter of width 3 to count 0..BL-1, reloaded at each burst start.
REQ-010 SHALL handle an entry that becomes due while a burst is active as follows: the entry keeps countdown 0, starts immediately after the current burst, and err_collision is set.
REQ-011 SHALL, on wr_issue with pend_full=1, drop the command, leave queue contents unchanged, and set err_overflow.
REQ-012 SHALL, when fifo_ren is required and fifo_empty=1, deassert fifo_ren for that beat, drive dq_out to all zeros with dq_valid=1, set err_underflow, and still count the beat.
REQ-013 SHALL accept a push and a pop in the same cycle when the queue is full; pend_full stays 1 and no overflow is flagged.
REQ-014 SHALL give err_clr lower priority than a same-cycle error set; the flag remains 1.
REQ-015 SHALL use queue read/write pointers that wrap modulo PEND_DEPTH, with one extra bit to distinguish full from empty.
REQ-016 SHALL drive dq_out to zero whenever dq_valid=0.

Reset
REQ-017 SHALL, while rst_n=0 at an edge, clear the queue pointers, select FSM IDLE, clear the beat counter, and set dq_out=0, dq_valid=0, all error flags=0.
REQ-018 SHALL hold fifo_ren=0, busy=0 and pend_full=0 during and immediately after reset.
REQ-019 SHALL, on reset asserted mid-burst, abort the burst without further fifo_ren; lost beats are not flagged.

Verification
REQ-020 Single write: cwl=5, bl8=0, wr_issue at cycle 10, FIFO preloaded with A..D -> fifo_ren cycles 14-17, dq_valid cycles 15-18 carrying A,B,C,D, no errors.
REQ-021 Back-to-back: cwl=4, bl8=0, wr_issue at cycles 10 and 14 -> dq_valid continuous in cycles 14-21, 8 beats in FIFO order, err_collision=0.
REQ-022 Collision: cwl=4, bl8=1, wr_issue at cycles 10 and 12 -> second burst dq_valid in cycles 22-29, err_collision=1.
REQ-023 Overflow: 5 wr_issue pulses in consecutive cycles with cwl=15 -> pend_full=1 after the 4th, 5th dropped, err_overflow=1, exactly 4 bursts emitted.
REQ-024 Underflow: cwl=3, bl8=0, only 2 words in FIFO -> beats 3-4 are zero with dq_valid=1 and err_underflow=1; err_clr then drops the flag to 0.
REQ-025 Reset mid-burst: rst_n=0 at the second beat -> next cycle dq_valid=0, busy=0, queue empty.

Source files
------------

// File: rtl/wdata_burst_sequencer_if.sv
// Write-issue command, write-data FIFO and PHY data signals of the write-data burst sequencer.
// The master drives commands and the FIFO head word; the slave pops the FIFO and drives PHY data.
interface wdata_burst_sequencer_if #(
    parameter int DW = 128
);
    logic          wr_issue;
    logic [3:0]    cwl;
    logic          bl8;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_ren;
    logic [DW-1:0] dq_out;
    logic          dq_valid;

    modport master (
        output wr_issue, cwl, bl8, fifo_empty, fifo_data,
        input  fifo_ren, dq_out, dq_valid
    );

    modport slave (
        input  wr_issue, cwl, bl8, fifo_empty, fifo_data,
        output fifo_ren, dq_out, dq_valid
    );
endinterface

// File: rtl/wdata_burst_sequencer.sv
// Times write-data bursts to the PHY: FIFO pops start cwl-1 cycles after wr_issue, data is registered one cycle later.
// No backpressure: a full pending queue drops the command, and an empty FIFO yields zero beats; both raise sticky flags.
module wdata_burst_sequencer #(
    parameter int DW         = 128,
    parameter int PEND_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    wdata_burst_sequencer_if.slave   bus,
    output logic                     pend_full,
    output logic                     busy,
    input  logic                     err_clr,
    output logic                     err_overflow,
    output logic                     err_underflow,
    output logic                     err_collision
);
    localparam int            AW      = $clog2(PEND_DEPTH);
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [0:0]    IDLE    = 1'b0;
    localparam logic [0:0]    BURST   = 1'b1;

    logic [3:0]            q_cnt [PEND_DEPTH];
    logic                  q_bl8 [PEND_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr, count;
    logic [AW-1:0]         head;
    logic [0:0]            state;
    logic [2:0]            bcnt;
    logic                  bl8_cur;
    logic                  empty, full, head_due, beat, start, burst_last, due_next;
    logic                  push_en, overflow, collision;
    logic [3:0]            cnt_init;
    logic [PEND_DEPTH-1:0] occupied;

    assign count    = wr_ptr - rd_ptr;
    assign head     = rd_ptr[AW-1:0];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_due = !empty && (q_cnt[head] == 4'd0);
    // bcnt==0 inside BURST only occurs for a burst chained directly onto the previous one
    assign start    = (state == IDLE) ? head_due : (bcnt == 3'd0);
    assign beat     = (state == BURST) || head_due;
    assign burst_last = (state == BURST) && (bcnt == (bl8_cur ? 3'd7 : 3'd3));
    assign cnt_init = (bus.cwl > 4'd2) ? bus.cwl - 4'd2 : 4'd0;
    assign push_en  = bus.wr_issue && (!full || start);
    assign overflow = bus.wr_issue && full && !start;
    assign due_next = empty ? (push_en && cnt_init == 4'd0) : (q_cnt[head] <= 4'd1);

    assign bus.fifo_ren = rst_n && beat && !bus.fifo_empty;
    assign busy         = rst_n && (!empty || state == BURST);
    assign pend_full    = rst_n && full;

    // Any queued entry already due but not starting this cycle is being held back.
    always_comb begin
        collision = 1'b0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            occupied[i] = {1'b0, AW'(i) - head} < count;
            if (occupied[i] && q_cnt[i] == 4'd0 && !(start && AW'(i) == head))
                collision = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PEND_DEPTH; i++)
            if (q_cnt[i] != 4'd0)
                q_cnt[i] <= q_cnt[i] - 4'd1;
        if (push_en) begin
            q_cnt[wr_ptr[AW-1:0]] <= cnt_init;
            q_bl8[wr_ptr[AW-1:0]] <= bus.bl8;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            state         <= IDLE;
            bcnt          <= 3'd0;
            bl8_cur       <= 1'b0;
            bus.dq_out    <= '0;
            bus.dq_valid  <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_collision <= 1'b0;
        end else begin
            if (push_en)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (start) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                bl8_cur <= q_bl8[head];
            end
            case (state)
                IDLE: begin
                    if (head_due) begin
                        state <= BURST;
                        bcnt  <= 3'd1;
                    end
                end
                BURST: begin
                    if (burst_last) begin
                        state <= due_next ? BURST : IDLE;
                        bcnt  <= 3'd0;
                    end else begin
                        bcnt  <= bcnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            bus.dq_valid  <= beat;
            bus.dq_out    <= (beat && !bus.fifo_empty) ? bus.fifo_data : '0;
            err_overflow  <= overflow || (err_overflow && !err_clr);
            err_underflow <= (beat && bus.fifo_empty) || (err_underflow && !err_clr);
            err_collision <= collision || (err_collision && !err_clr);
        end
    end
endmodule

// File: tb/tb_wdata_burst_sequencer.sv
// Scoreboard bench: each accepted command pushes its expected beats; a negedge monitor checks PHY and status outputs.
module tb_wdata_burst_sequencer;
    localparam int DW   = 128;
    localparam int PEND = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clr = 1'b0;
    logic pend_full, busy, err_overflow, err_underflow, err_collision;

    wdata_burst_sequencer_if #(.DW(DW)) bus ();

    wdata_burst_sequencer #(.DW(DW), .PEND_DEPTH(PEND)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .pend_full     (pend_full),
        .busy          (busy),
        .err_clr       (err_clr),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_collision (err_collision)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check_bit(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_dat(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: each burst starts at its due cycle or right after the previous burst, whichever is later.
    typedef struct { int ti; int s; int bl; } ent_t;
    typedef struct { int c; logic [DW-1:0] d; } beat_t;
    ent_t          ents[$];
    beat_t         sb[$];
    bit            exp_ren[int];
    logic [DW-1:0] words[$];
    logic [DW-1:0] fq[$];
    int            beat_idx = 0;
    int            last_end = -1000;
    bit            exp_ovf = 0, exp_und = 0, exp_coll = 0;

    function automatic void fifo_out();
        bus.fifo_empty = (fq.size() == 0);
        bus.fifo_data  = (fq.size() != 0) ? fq[0] : '0;
    endfunction

    function automatic void model_issue(int tc, int cw, bit b8);
        int occ = 0;
        bit popping = 0;
        int due, s, bl;
        foreach (ents[i])
            if (ents[i].ti < tc && ents[i].s >= tc) begin
                occ++;
                if (ents[i].s == tc) popping = 1;
            end
        if (occ >= PEND && !popping) begin
            exp_ovf = 1;
            return;
        end
        due = tc + cw - 1;
        bl  = b8 ? 8 : 4;
        s   = (due > last_end) ? due : last_end + 1;
        if (s > due) exp_coll = 1;
        last_end = s + bl - 1;
        ents.push_back('{ti: tc, s: s, bl: bl});
        for (int j = 0; j < bl; j++) begin
            beat_t b;
            if (beat_idx < int'(words.size())) begin
                b.d = words[beat_idx];
                exp_ren[s + j] = 1;
            end else begin
                b.d = '0;
                exp_und = 1;
            end
            beat_idx++;
            b.c = s + j + 1;
            sb.push_back(b);
        end
    endfunction

    function automatic void model_reset();
        for (int k = cyc; k < cyc + 1000; k++)
            if (exp_ren.exists(k)) exp_ren.delete(k);
        while (sb.size() > 0 && sb[$].c > cyc) void'(sb.pop_back());
        ents.delete();
        last_end = -1000;
        exp_ovf  = 0;
        exp_und  = 0;
        exp_coll = 0;
    endfunction

    logic ren_s = 1'b0;
    always @(negedge clk) ren_s = bus.fifo_ren;
    always @(posedge clk) begin
        #1;
        if (ren_s && fq.size() > 0) void'(fq.pop_front());
        fifo_out();
    end

    always @(negedge clk) begin
        int occ;
        bit eb;
        beat_t b;
        if (!rst_n) begin
            check_bit("fifo_ren_in_reset", bus.fifo_ren, 1'b0);
            check_bit("busy_in_reset", busy, 1'b0);
            check_bit("pend_full_in_reset", pend_full, 1'b0);
        end else begin
            occ = 0;
            eb  = 0;
            foreach (ents[i]) begin
                if (ents[i].ti < cyc && cyc <= ents[i].s) occ++;
                if (ents[i].ti < cyc && cyc <= ents[i].s + ents[i].bl - 1) eb = 1;
            end
            check_bit("fifo_ren", bus.fifo_ren, exp_ren.exists(cyc));
            check_bit("busy", busy, eb);
            check_bit("pend_full", pend_full, occ == PEND);
        end
        if (bus.dq_valid) begin
            if (sb.size() == 0) begin
                check_bit("dq_valid_unexpected", bus.dq_valid, 1'b0);
            end else begin
                b = sb.pop_front();
                check_int("dq_beat_cycle", cyc, b.c);
                check_dat("dq_data", bus.dq_out, b.d);
            end
        end else begin
            if (sb.size() > 0 && sb[0].c <= cyc) begin
                check_bit("dq_valid_missing", bus.dq_valid, 1'b1);
                void'(sb.pop_front());
            end
            check_dat("dq_idle_zero", bus.dq_out, '0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.wr_issue = 1'b0;
        err_clr      = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic preload(int n);
        fq.delete();
        words.delete();
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] w;
            w = {$urandom, $urandom, $urandom, $urandom};
            fq.push_back(w);
            words.push_back(w);
        end
        beat_idx = 0;
        fifo_out();
    endtask

    task automatic issue(int cw, bit b8);
        bus.wr_issue = 1'b1;
        bus.cwl      = 4'(cw);
        bus.bl8      = b8;
        model_issue(cyc, cw, b8);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() > 0 || busy) && n < 600) begin
            tick();
            n++;
        end
        check_bit("drain_complete", sb.size() == 0, 1'b1);
        tick();
        tick();
    endtask

    task automatic check_flags();
        check_bit("err_overflow", err_overflow, exp_ovf);
        check_bit("err_underflow", err_underflow, exp_und);
        check_bit("err_collision", err_collision, exp_coll);
    endtask

    initial begin
        bus.wr_issue = 1'b0;
        bus.cwl      = 4'd4;
        bus.bl8      = 1'b0;
        fifo_out();
        repeat (3) tick();
        do_reset();
        check_flags();

        // single write
        preload(8);
        repeat (5) tick();
        issue(5, 1'b0);
        tick();
        drain();
        check_flags();

        // back-to-back bursts chained without a gap
        do_reset();
        preload(16);
        tick();
        issue(4, 1'b0);
        repeat (4) tick();
        issue(4, 1'b0);
        tick();
        drain();
        check_flags();

        // second burst due while the first is running
        do_reset();
        preload(16);
        tick();
        issue(4, 1'b1);
        repeat (2) tick();
        issue(4, 1'b1);
        tick();
        drain();
        check_flags();

        // five commands into a four-entry queue
        do_reset();
        preload(32);
        tick();
        for (int i = 0; i < 5; i++) begin
            issue(15, 1'b0);
            tick();
        end
        drain();
        check_flags();

        // FIFO runs dry, then the sticky flag is cleared
        do_reset();
        preload(2);
        tick();
        issue(3, 1'b0);
        tick();
        drain();
        check_flags();
        err_clr = 1'b1;
        exp_und = 0;
        tick();
        check_flags();

        // reset lands on the second beat
        do_reset();
        preload(8);
        tick();
        issue(4, 1'b0);
        repeat (4) tick();
        do_reset();
        tick();
        check_flags();
        drain();

        // randomized traffic, plenty of data
        do_reset();
        preload(600);
        tick();
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 10)) tick();
            issue($urandom_range(2, 15), 1'($urandom_range(0, 1)));
            tick();
        end
        drain();
        check_flags();

        // randomized traffic that outruns the FIFO contents
        do_reset();
        preload(40);
        tick();
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 4)) tick();
            issue($urandom_range(2, 15), 1'($urandom_range(0, 1)));
            tick();
        end
        drain();
        check_flags();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
